reg_debug_port: RTL and testbench

Debug access controller for the integer register file. Serves read/write requests from the debug/loader interface. For each request it:
- halts instruction issue,
- waits for the pipeline (RR/EX/MEM/WB) to drain,
- takes over read port 0 and the write port for one access,
- returns data over a 4-phase req/ack handshake.

Outside debug accesses the pipeline writeback passes straight through to the register file write port.

---
 rtl/reg_debug_port.sv | 131 +++++++++++++
 tb/tb_reg_debug_port.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_debug_port.sv
// Debug access controller for the integer register file: halts issue, waits for the
// pipeline to drain, performs one read or write, and answers on a 4-phase req/ack handshake.
module reg_debug_port #(
    parameter int TIMEOUT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic        halt,
    input  logic        pipe_busy,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        rf_rd0_ovr,
    output logic [4:0]  rf_rd0_addr,
    input  logic [31:0] rf_rd0_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ACCESS,
        S_CAPTURE,
        S_ACK
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TMO_MAX = '1;

    state_t               state;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 req_we;
    logic [4:0]           req_addr;
    logic [31:0]          req_wdata;
    logic                 drained;
    logic                 dbg_write_now;

    assign drained       = !pipe_busy && !wb_we;
    // A pipeline writeback arriving during ACCESS keeps the port; the debug write waits.
    assign dbg_write_now = (state == S_ACCESS) && req_we && !wb_we;

    always_comb begin
        rf_we = wb_we;
        rf_wa = wb_rd;
        rf_wd = wb_data;
        if (dbg_write_now) begin
            rf_we = (req_addr != 5'd0);
            rf_wa = req_addr;
            rf_wd = req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && dbg_req) begin
            req_we    <= dbg_we;
            req_addr  <= dbg_addr;
            req_wdata <= dbg_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            halt        <= 1'b0;
            dbg_ack     <= 1'b0;
            dbg_err     <= 1'b0;
            dbg_rdata   <= '0;
            rf_rd0_ovr  <= 1'b0;
            rf_rd0_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dbg_req) begin
                        state   <= S_DRAIN;
                        halt    <= 1'b1;
                        tmo_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        state <= S_ACCESS;
                        if (!req_we) begin
                            rf_rd0_ovr  <= 1'b1;
                            rf_rd0_addr <= req_addr;
                        end
                    end else if (tmo_cnt == TMO_MAX) begin
                        state   <= S_ACK;
                        dbg_err <= 1'b1;
                        dbg_ack <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (!req_we) begin
                        state <= S_CAPTURE;
                    end else if (!wb_we) begin
                        state   <= S_ACK;
                        dbg_ack <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // Read data from the synchronous port is valid in this cycle.
                    dbg_rdata  <= (req_addr == 5'd0) ? 32'd0 : rf_rd0_data;
                    rf_rd0_ovr <= 1'b0;
                    dbg_ack    <= 1'b1;
                    state      <= S_ACK;
                end
                S_ACK: begin
                    if (!dbg_req) begin
                        state   <= S_IDLE;
                        dbg_ack <= 1'b0;
                        dbg_err <= 1'b0;
                        halt    <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_debug_port.sv
// Bench for reg_debug_port: table of directed transactions, hand-written corner sequences,
// and randomized transactions checked against a register-file model.
module tb_reg_debug_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_err;
    logic        halt;
    logic        pipe_busy;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        rf_rd0_ovr;
    logic [4:0]  rf_rd0_addr;
    logic [31:0] rf_rd0_data;

    reg_debug_port #(.TIMEOUT_W(4)) dut (
        .clk(clk), .rst(rst),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err), .halt(halt),
        .pipe_busy(pipe_busy), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .rf_rd0_ovr(rf_rd0_ovr), .rf_rd0_addr(rf_rd0_addr), .rf_rd0_data(rf_rd0_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        int          busy;
        int          exp_lat;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_we;
        int          exp_ovr;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        env_init;
    logic [31:0] env_rf   [32];
    logic [31:0] model_rf [32];
    logic [31:0] model_rdata;
    vec_t        tbl [11];

    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'hFFFF_FFFF;
        if (i == 7) return 32'h1234_5678;
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Register file seen by the DUT: synchronous read port 0, one write port.
    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 32; i++) env_rf[i] <= init_val(i);
        end else if (rf_we) begin
            env_rf[rf_wa] <= rf_wd;
        end
        rf_rd0_data <= env_rf[rf_rd0_ovr ? rf_rd0_addr : 5'd0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic release_req(input string tag);
        dbg_req = 1'b0;
        @(posedge clk); #1;
        check({tag, " ack_drop"},  32'(dbg_ack), 32'd0);
        check({tag, " halt_drop"}, 32'(halt),    32'd0);
        check({tag, " err_drop"},  32'(dbg_err), 32'd0);
    endtask

    task automatic apply(input vec_t v, input string tag);
        int cyc = 0, we_cnt = 0, ovr_cnt = 0, halt_bad = 0, port_bad = 0;
        bit done = 1'b0;
        dbg_req   = 1'b1;
        dbg_we    = v.we;
        dbg_addr  = v.addr;
        dbg_wdata = v.wdata;
        pipe_busy = 1'b0;
        wb_we     = 1'b0;
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                dbg_addr  = ~v.addr;
                dbg_wdata = ~v.wdata;
            end
            if (!halt) halt_bad++;
            if (rf_we) begin
                we_cnt++;
                if (rf_wa !== v.addr || rf_wd !== v.wdata) port_bad++;
            end
            if (rf_rd0_ovr) begin
                ovr_cnt++;
                if (rf_rd0_addr !== v.addr) port_bad++;
            end
            if (dbg_ack) done = 1'b1;
            else pipe_busy = (cyc <= v.busy);
        end
        pipe_busy = 1'b0;
        check({tag, " ack_seen"}, 32'(dbg_ack), 32'd1);
        check({tag, " latency"},  32'(cyc), 32'(v.exp_lat));
        check({tag, " rdata"},    dbg_rdata, v.exp_rdata);
        check({tag, " err"},      32'(dbg_err), 32'(v.exp_err));
        check({tag, " we_cycles"},  32'(we_cnt), 32'(v.exp_we));
        check({tag, " ovr_cycles"}, 32'(ovr_cnt), 32'(v.exp_ovr));
        check({tag, " halt_held"},  32'(halt_bad), 32'd0);
        check({tag, " port_addr"},  32'(port_bad), 32'd0);
        release_req(tag);
        if (v.we && v.busy < 16 && v.addr != 5'd0) model_rf[v.addr] = v.wdata;
        model_rdata = v.exp_rdata;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst = 1'b1; env_init = 1'b1;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        pipe_busy = 1'b0; wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'h1357_9BDF;
        for (int i = 0; i < 32; i++) model_rf[i] = init_val(i);
        model_rdata = '0;
        #3;
        check("rst halt", 32'(halt), 32'd0);
        check("rst ack",  32'(dbg_ack), 32'd0);
        check("rst err",  32'(dbg_err), 32'd0);
        check("rst rdata", dbg_rdata, 32'd0);
        check("rst ovr",  32'(rf_rd0_ovr), 32'd0);
        check("rst rd0_addr", 32'(rf_rd0_addr), 32'd0);
        check("rst pass_we", 32'(rf_we), 32'd1);
        check("rst pass_wa", 32'(rf_wa), 32'd10);
        check("rst pass_wd", rf_wd, 32'h1357_9BDF);
        tick; tick;
        wb_we = 1'b0; rst = 1'b0; env_init = 1'b0;
        tick;

        tbl[0]  = '{1'b1, 5'd5, 32'hDEAD_BEEF,  0,  3, 32'h0,         1'b0, 1, 0};
        tbl[1]  = '{1'b0, 5'd7, 32'h0,          0,  4, 32'h1234_5678, 1'b0, 0, 2};
        tbl[2]  = '{1'b0, 5'd5, 32'h0,          0,  4, 32'hDEAD_BEEF, 1'b0, 0, 2};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,          0,  4, 32'h0,         1'b0, 0, 2};
        tbl[4]  = '{1'b1, 5'd0, 32'h1,          0,  3, 32'h0,         1'b0, 0, 0};
        tbl[5]  = '{1'b0, 5'd7, 32'h0,          3,  7, 32'h1234_5678, 1'b0, 0, 2};
        tbl[6]  = '{1'b1, 5'd9, 32'h1111_1111, 16, 17, 32'h1234_5678, 1'b1, 0, 0};
        tbl[7]  = '{1'b0, 5'd9, 32'h0,         15, 19, 32'hA500_0009, 1'b0, 0, 2};
        tbl[8]  = '{1'b1, 5'd9, 32'h0BAD_F00D,  2,  5, 32'hA500_0009, 1'b0, 1, 0};
        tbl[9]  = '{1'b0, 5'd9, 32'h0,          0,  4, 32'h0BAD_F00D, 1'b0, 0, 2};
        tbl[10] = '{1'b0, 5'd0, 32'h0,         20, 17, 32'h0BAD_F00D, 1'b1, 0, 0};
        for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Pipeline writebacks during DRAIN pass through; ACCESS waits for busy=0 and wb_we=0.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
        tick;
        check("drain halt", 32'(halt), 32'd1);
        pipe_busy = 1'b1; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
        #1;
        check("drain pass_we", 32'(rf_we), 32'd1);
        check("drain pass_wa", 32'(rf_wa), 32'd3);
        check("drain pass_wd", rf_wd, 32'h55);
        tick; wb_we = 1'b0;
        tick;
        tick; pipe_busy = 1'b0; wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h66;
        tick;
        check("drain wb_blocks", 32'(rf_rd0_ovr), 32'd0);
        wb_we = 1'b0;
        tick;
        check("access ovr", 32'(rf_rd0_ovr), 32'd1);
        check("access rd0_addr", 32'(rf_rd0_addr), 32'd3);
        tick;
        check("capture ovr", 32'(rf_rd0_ovr), 32'd1);
        tick;
        check("drainrd ack", 32'(dbg_ack), 32'd1);
        check("drainrd rdata", dbg_rdata, 32'h55);
        check("drainrd err", 32'(dbg_err), 32'd0);
        release_req("drainrd");
        model_rf[3] = 32'h55; model_rf[4] = 32'h66; model_rdata = 32'h55;

        // Writeback colliding with a debug write in ACCESS takes the port first.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd6; dbg_wdata = 32'h77;
        tick; tick;
        check("coll dbg_wa", 32'(rf_wa), 32'd6);
        wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'h88;
        #1;
        check("coll wb_wa", 32'(rf_wa), 32'd8);
        check("coll wb_wd", rf_wd, 32'h88);
        tick;
        check("coll no_ack", 32'(dbg_ack), 32'd0);
        wb_we = 1'b0;
        #1;
        check("coll late_we", 32'(rf_we), 32'd1);
        check("coll late_wa", 32'(rf_wa), 32'd6);
        check("coll late_wd", rf_wd, 32'h77);
        tick;
        check("coll ack", 32'(dbg_ack), 32'd1);
        release_req("coll");
        model_rf[6] = 32'h77; model_rf[8] = 32'h88;
        v = '{1'b0, 5'd8, 32'h0, 0, 4, 32'h88, 1'b0, 0, 2};
        apply(v, "coll_rd8");

        // Asynchronous reset in DRAIN, ACK and ACCESS.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7; pipe_busy = 1'b1;
        tick; tick; tick;
        rst = 1'b1; #1;
        check("rstdrain halt", 32'(halt), 32'd0);
        check("rstdrain ack", 32'(dbg_ack), 32'd0);
        check("rstdrain ovr", 32'(rf_rd0_ovr), 32'd0);
        dbg_req = 1'b0; pipe_busy = 1'b0;
        tick; rst = 1'b0; tick;
        v = '{1'b0, 5'd7, 32'h0, 0, 4, 32'h1234_5678, 1'b0, 0, 2};
        apply(v, "after_rstdrain");

        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd10; dbg_wdata = 32'hCAFE_0010;
        tick; tick; tick;
        check("rstack pre_ack", 32'(dbg_ack), 32'd1);
        rst = 1'b1; #1;
        check("rstack halt", 32'(halt), 32'd0);
        check("rstack ack", 32'(dbg_ack), 32'd0);
        check("rstack rdata", dbg_rdata, 32'd0);
        dbg_req = 1'b0;
        tick; rst = 1'b0; tick;
        model_rf[10] = 32'hCAFE_0010;

        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd10;
        tick; tick;
        check("rstacc pre_ovr", 32'(rf_rd0_ovr), 32'd1);
        rst = 1'b1; #1;
        check("rstacc ovr", 32'(rf_rd0_ovr), 32'd0);
        check("rstacc halt", 32'(halt), 32'd0);
        dbg_req = 1'b0;
        tick; rst = 1'b0; tick;
        v = '{1'b0, 5'd10, 32'h0, 0, 4, 32'hCAFE_0010, 1'b0, 0, 2};
        apply(v, "after_rstacc");

        for (int n = 0; n < 40; n++) begin
            bit to;
            v.we    = ($urandom % 2) == 1;
            v.addr  = 5'($urandom % 32);
            v.wdata = $urandom;
            v.busy  = ($urandom % 5 == 0) ? int'($urandom_range(20, 16)) : int'($urandom_range(4, 0));
            to = (v.busy >= 16);
            v.exp_lat = to ? 17 : v.busy + (v.we ? 3 : 4);
            v.exp_err = to;
            v.exp_rdata = (!to && !v.we) ? ((v.addr == 5'd0) ? 32'd0 : model_rf[v.addr]) : model_rdata;
            v.exp_we  = (!to && v.we && v.addr != 5'd0) ? 1 : 0;
            v.exp_ovr = (!to && !v.we) ? 2 : 0;
            apply(v, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
